// File: rtl/sdrc_dbuf_pkg.sv
// Shared constants and entry layouts for the
// SDRAM application data staging buffer.
package sdrc_dbuf_pkg;

  localparam int DBUF_APP_DW    = 32;
  localparam int DBUF_APP_BW    = DBUF_APP_DW / 8;
  localparam int DBUF_DEPTH_LG2 = 4;
  localparam int DBUF_BURST_MAX = 8;
  localparam int DBUF_DEPTH     = 2 ** DBUF_DEPTH_LG2;

  typedef struct packed {
    logic [DBUF_APP_BW-1:0] be_n;
    logic [DBUF_APP_DW-1:0] data;
  } wr_ent_t;

  typedef struct packed {
    logic                   last;
    logic [DBUF_APP_DW-1:0] data;
  } rd_ent_t;

endpackage

// File: rtl/sdrc_app_dbuf_if.sv
// Host and converter side signals of the
// application data staging buffer.
interface sdrc_app_dbuf_if #(
  parameter int APP_DW    = 32,
  parameter int APP_BW    = 4,
  parameter int DEPTH_LG2 = 4
);
  logic [APP_DW-1:0]    wr_dat_i;
  logic [APP_BW-1:0]    wr_be_n_i;
  logic                 wr_vld_i;
  logic                 wr_rdy_o;
  logic [APP_DW-1:0]    app_wr_data;
  logic [APP_BW-1:0]    app_wr_en_n;
  logic                 app_wr_next;
  logic [APP_DW-1:0]    app_rd_data;
  logic                 app_rd_valid;
  logic                 app_last_rd;
  logic [APP_DW-1:0]    rd_dat_o;
  logic                 rd_last_o;
  logic                 rd_vld_o;
  logic                 rd_rdy_i;
  logic                 rd_space_o;
  logic [DEPTH_LG2:0]   wr_lvl_o;
  logic [DEPTH_LG2:0]   rd_lvl_o;
  logic                 err_clr_i;
  logic                 wr_uflow_o;
  logic                 rd_oflow_o;

  modport slave (
    input  wr_dat_i, wr_be_n_i, wr_vld_i,
    input  app_wr_next,
    input  app_rd_data, app_rd_valid,
    input  app_last_rd,
    input  rd_rdy_i, err_clr_i,
    output wr_rdy_o, app_wr_data,
    output app_wr_en_n,
    output rd_dat_o, rd_last_o, rd_vld_o,
    output rd_space_o, wr_lvl_o, rd_lvl_o,
    output wr_uflow_o, rd_oflow_o
  );

  modport master (
    output wr_dat_i, wr_be_n_i, wr_vld_i,
    output app_wr_next,
    output app_rd_data, app_rd_valid,
    output app_last_rd,
    output rd_rdy_i, err_clr_i,
    input  wr_rdy_o, app_wr_data,
    input  app_wr_en_n,
    input  rd_dat_o, rd_last_o, rd_vld_o,
    input  rd_space_o, wr_lvl_o, rd_lvl_o,
    input  wr_uflow_o, rd_oflow_o
  );
endinterface

// File: rtl/sdrc_sync_fifo.sv
// First-word-fall-through synchronous FIFO;
// head reads zero while empty.
module sdrc_sync_fifo #(
  parameter int W   = 36,
  parameter int LG2 = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [LG2:0] level,
  output logic [LG2:0] level_nxt,
  output logic [W-1:0] head
);
  localparam int D = 2 ** LG2;

  logic [W-1:0] mem [D];
  logic [LG2:0] wptr;
  logic [LG2:0] rptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[LG2] != rptr[LG2]) &&
                 (wptr[LG2-1:0] == rptr[LG2-1:0]);

  // a full FIFO still takes a push when it pops
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign level     = wptr - rptr;
  assign level_nxt = level
                   + (LG2+1)'(do_push)
                   - (LG2+1)'(do_pop);

  assign head = empty ? '0 : mem[rptr[LG2-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[LG2-1:0]] <= din;
  end

endmodule

// File: rtl/sdrc_app_dbuf.sv
// Write and read staging FIFOs between host and
// the SDRAM width converter, with status flags.
module sdrc_app_dbuf
  import sdrc_dbuf_pkg::*;
#(
  parameter int APP_DW    = DBUF_APP_DW,
  parameter int APP_BW    = DBUF_APP_BW,
  parameter int DEPTH_LG2 = DBUF_DEPTH_LG2,
  parameter int BURST_MAX = DBUF_BURST_MAX
) (
  input logic              clk,
  input logic              reset_n,
  sdrc_app_dbuf_if.slave   bus
);
  localparam int DEPTH = 2 ** DEPTH_LG2;
  localparam int LW    = DEPTH_LG2 + 1;

  wr_ent_t       wr_in;
  wr_ent_t       wr_head;
  rd_ent_t       rd_in;
  rd_ent_t       rd_head;
  logic          wr_full;
  logic          wr_empty;
  logic          rd_full;
  logic          rd_empty;
  logic [LW-1:0] wr_lvl;
  logic [LW-1:0] wr_lvl_nxt;
  logic [LW-1:0] rd_lvl;
  logic [LW-1:0] rd_lvl_nxt;
  logic          wr_rdy_q;
  logic          rd_space_q;
  logic          wr_uflow_q;
  logic          rd_oflow_q;
  logic          wr_push;
  logic          rd_pop;
  logic          uflow_set;
  logic          oflow_set;

  assign wr_in   = {bus.wr_be_n_i, bus.wr_dat_i};
  assign rd_in   = {bus.app_last_rd, bus.app_rd_data};
  assign wr_push = bus.wr_vld_i & wr_rdy_q & ~wr_full;
  assign rd_pop  = ~rd_empty & bus.rd_rdy_i;

  sdrc_sync_fifo #(
    .W   (APP_DW + APP_BW),
    .LG2 (DEPTH_LG2)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_push),
    .pop       (bus.app_wr_next),
    .din       (wr_in),
    .full      (wr_full),
    .empty     (wr_empty),
    .level     (wr_lvl),
    .level_nxt (wr_lvl_nxt),
    .head      (wr_head)
  );

  sdrc_sync_fifo #(
    .W   (APP_DW + 1),
    .LG2 (DEPTH_LG2)
  ) u_rd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (bus.app_rd_valid),
    .pop       (rd_pop),
    .din       (rd_in),
    .full      (rd_full),
    .empty     (rd_empty),
    .level     (rd_lvl),
    .level_nxt (rd_lvl_nxt),
    .head      (rd_head)
  );

  assign uflow_set = bus.app_wr_next & wr_empty;
  assign oflow_set = bus.app_rd_valid & rd_full & ~rd_pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_rdy_q   <= 1'b1;
      rd_space_q <= 1'b1;
      wr_uflow_q <= 1'b0;
      rd_oflow_q <= 1'b0;
    end else begin
      wr_rdy_q   <= (wr_lvl_nxt != LW'(DEPTH));
      rd_space_q <= (rd_lvl_nxt <= LW'(DEPTH - BURST_MAX));
      // a fresh error outranks a clear in the same cycle
      if (uflow_set)          wr_uflow_q <= 1'b1;
      else if (bus.err_clr_i) wr_uflow_q <= 1'b0;
      if (oflow_set)          rd_oflow_q <= 1'b1;
      else if (bus.err_clr_i) rd_oflow_q <= 1'b0;
    end
  end

  assign bus.wr_rdy_o    = wr_rdy_q;
  assign bus.app_wr_data = wr_head.data;
  assign bus.app_wr_en_n = wr_empty ? '1 : wr_head.be_n;
  assign bus.rd_dat_o    = rd_head.data;
  assign bus.rd_last_o   = rd_head.last;
  assign bus.rd_vld_o    = ~rd_empty;
  assign bus.rd_space_o  = rd_space_q;
  assign bus.wr_lvl_o    = wr_lvl;
  assign bus.rd_lvl_o    = rd_lvl;
  assign bus.wr_uflow_o  = wr_uflow_q;
  assign bus.rd_oflow_o  = rd_oflow_q;

endmodule
